// File: rtl/vga_capture.sv
// Purpose: VGA receive front end; recovers line/frame timing from hs/vs, checks the raster, emits (x,y) pixels.
// Latency: every output lags the hs/vs/rgb pins by 2 clk (one input sample stage plus registered outputs).
// Backpressure: none; the pixel stream is free-running and px_valid cannot be stalled by a consumer.
module vga_capture #(
  parameter int BPP         = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 524,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 31,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             vs,
  input  logic [3*BPP-1:0] rgb,
  output logic             px_valid,
  output logic [9:0]       px_x,
  output logic [9:0]       px_y,
  output logic [3*BPP-1:0] px_data,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             err
);

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_LO       = 10'(H_START);
  localparam logic [9:0]  H_HI       = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO       = 10'(V_START);
  localparam logic [9:0]  V_HI       = 10'(V_START + V_ACTIVE);
  localparam logic [9:0]  CNT_MAX    = 10'h3FF;
  localparam logic [10:0] IDLE_MAX   = 11'h7FF;
  localparam logic [10:0] IDLE_LIMIT = 11'(2 * H_TOTAL);
  localparam logic [2:0]  LOCK_N     = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // stage-0 samples and the previous sample used for edge detection
  logic             hs_s, vs_s, hs_p, vs_p;
  logic [3*BPP-1:0] rgb_s;

  // timing recovery state
  logic [9:0]  hcnt, vcnt;
  logic [10:0] idle_cnt;
  logic        vs_seen;
  logic        bad_acc;
  state_t      state;
  logic [2:0]  good_cnt;

  // next-value and decision terms, all derived from stage 0
  logic        hs_fall, vs_fall, line0;
  logic        line_bad, frame_bad, timeout;
  logic [9:0]  h_next, v_next;
  logic [10:0] idle_next;
  logic [2:0]  good_inc;
  logic        lock_fault, drop_lock, become_locked, locked_next;
  logic        in_win, px_hit;

  assign hs_fall = hs_p & ~hs_s;
  assign vs_fall = vs_p & ~vs_s;

  // a vs fall coincident with the hs fall counts as the same line 0
  assign line0 = hs_fall & ~vs_s & (vs_seen | vs_fall);

  // a line is judged when the next one starts; the closing line belongs to the old frame
  assign line_bad  = hs_fall & (hcnt != H_LAST);
  assign frame_bad = line0 & ((vcnt != V_LAST) | bad_acc | line_bad);

  assign h_next = hs_fall ? 10'd0
                : (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;

  assign v_next = line0   ? 10'd0
                : !hs_fall ? vcnt
                : (vcnt == CNT_MAX) ? vcnt : vcnt + 10'd1;

  // hcnt saturates well below two line periods, so loss of sync needs its own wider counter
  assign idle_next = (hs_fall | vs_fall) ? 11'd0
                   : (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 11'd1;
  assign timeout   = (idle_next == IDLE_LIMIT);

  assign good_inc      = good_cnt + 3'd1;
  assign lock_fault    = line_bad | frame_bad | timeout;
  assign drop_lock     = (state == LOCKED) & lock_fault;
  assign become_locked = (state == ACQUIRE) & line0 & ~frame_bad & (good_inc == LOCK_N);
  assign locked_next   = ((state == LOCKED) & ~lock_fault) | become_locked;

  assign in_win = (h_next >= H_LO) && (h_next < H_HI) && (v_next >= V_LO) && (v_next < V_HI);
  assign px_hit = locked_next & in_win;

  // sample the pins once; syncs idle high so reset never looks like a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s  <= 1'b1;
      vs_s  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      rgb_s <= '0;
    end else begin
      hs_p  <= hs_s;
      vs_p  <= vs_s;
      hs_s  <= hs;
      vs_s  <= vs;
      rgb_s <= rgb;
    end
  end

  // raster position, sync idle time, and per-frame bad-line memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      idle_cnt <= '0;
      vs_seen  <= 1'b0;
      bad_acc  <= 1'b0;
    end else begin
      hcnt     <= h_next;
      vcnt     <= v_next;
      idle_cnt <= idle_next;
      if (hs_fall) begin
        vs_seen <= 1'b0;
      end else if (vs_fall) begin
        vs_seen <= 1'b1;
      end
      if (line0) begin
        bad_acc <= 1'b0;
      end else if (line_bad) begin
        bad_acc <= 1'b1;
      end
    end
  end

  // lock FSM together with its registered outputs and the qualified pixel stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      good_cnt    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_data     <= '0;
    end else begin
      line_start  <= hs_fall;
      frame_start <= line0;
      locked      <= locked_next;
      err         <= drop_lock;
      px_valid    <= px_hit;
      if (px_hit) begin
        px_x    <= h_next - H_LO;
        px_y    <= v_next - V_LO;
        px_data <= rgb_s;
      end
      case (state)
        SEEK: begin
          if (line0) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          // any timing fault while acquiring restarts the search quietly
          if (line_bad | frame_bad) begin
            state <= SEEK;
          end else if (line0) begin
            good_cnt <= good_inc;
            if (good_inc == LOCK_N) begin
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (drop_lock) begin
            state <= SEEK;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Purpose: randomized raster stimulus for vga_capture, checked every cycle against a line/frame-level model.
// Latency: model results are shown one clock after the sample they belong to, matching the 2-clk pin lag.
// Backpressure: none; the generator free-runs and the bench only observes.
module tb_vga_capture;

  localparam int BPP         = 4;
  localparam int H_TOTAL     = 40;
  localparam int V_TOTAL     = 20;
  localparam int H_START     = 8;
  localparam int H_ACTIVE    = 24;
  localparam int V_START     = 3;
  localparam int V_ACTIVE    = 12;
  localparam int LOCK_FRAMES = 2;
  localparam int HS_WIDTH    = 4;
  localparam int VS_LINES    = 2;
  localparam int FRAME_PX    = H_ACTIVE * V_ACTIVE;

  typedef struct packed {
    logic        pv;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] d;
    logic        ls;
    logic        fs;
    logic        lk;
    logic        er;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [11:0] rgb = '0;
  logic        px_valid, line_start, frame_start, locked, err;
  logic [9:0]  px_x, px_y;
  logic [11:0] px_data;
  obs_t        obs;

  int checks = 0;
  int failures = 0;

  vga_capture #(
    .BPP(BPP), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_START(H_START),
    .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb(rgb),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .line_start(line_start), .frame_start(frame_start), .locked(locked), .err(err)
  );

  assign obs = {px_valid, px_x, px_y, px_data, line_start, frame_start, locked, err};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: line lengths, frame line counts, lock bookkeeping
  int   m_h, m_v, m_idle, m_state, m_good;
  bit   m_vs_seen, m_bad_acc, m_prev_hs, m_prev_vs;
  obs_t e_cur, e_show;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_idle = 0; m_state = 0; m_good = 0;
    m_vs_seen = 0; m_bad_acc = 0; m_prev_hs = 1; m_prev_vs = 1;
    e_cur = '0; e_show = '0;
  endtask

  task automatic model_step();
    bit hf, vf, ln0, lbad, fbad, tmo, er, pv;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    ln0 = 0; lbad = 0; fbad = 0;
    if (hf) begin
      lbad = (m_h != H_TOTAL - 1);
      ln0 = !vs && (m_vs_seen || vf);
      if (ln0) begin
        fbad = (m_v + 1 != V_TOTAL) || m_bad_acc || lbad;
        m_v = 0;
        m_bad_acc = 0;
      end else begin
        m_v++;
        m_bad_acc = m_bad_acc || lbad;
      end
      m_h = 0;
    end else begin
      m_h++;
    end
    if (hf) m_vs_seen = 0;
    else if (vf) m_vs_seen = 1;
    m_idle = (hf || vf) ? 0 : m_idle + 1;
    tmo = (m_idle == 2 * H_TOTAL);
    er = 0;
    case (m_state)
      0: if (ln0) begin m_state = 1; m_good = 0; end
      1: begin
        if (lbad || fbad) m_state = 0;
        else if (ln0) begin
          m_good++;
          if (m_good == LOCK_FRAMES) m_state = 2;
        end
      end
      default: if (lbad || fbad || tmo) begin er = 1; m_state = 0; end
    endcase
    pv = (m_state == 2) && m_h >= H_START && m_h < H_START + H_ACTIVE
         && m_v >= V_START && m_v < V_START + V_ACTIVE;
    e_cur.pv = pv;
    if (pv) begin
      e_cur.x = 10'(m_h - H_START);
      e_cur.y = 10'(m_v - V_START);
      e_cur.d = rgb;
    end
    e_cur.ls = hf;
    e_cur.fs = ln0;
    e_cur.lk = (m_state == 2);
    e_cur.er = er;
    m_prev_hs = hs;
    m_prev_vs = vs;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      e_show = e_cur;
      model_step();
    end
  end

  // ---------------- compare process and event bookkeeping
  bit  run = 0;
  int  cyc = 0;
  int  px_total = 0, err_total = 0, lock_rises = 0, fs_count = 0;
  int  rise_fs = 0, rise_fs_count = 0;
  int  last_ls_cyc = 0, err_gap = -1;
  bit  lk_prev = 0, first_seen = 0;
  int  first_x = -1, first_y = -1;

  always @(negedge clk) begin
    cyc++;
    if (run) begin
      if (!rst_n) check("outputs_in_reset", obs, 64'(0));
      else        check("outputs_vs_model", obs, e_show);
      if (px_valid) check("px_data_pattern", px_data, {px_x[3:0], px_y[3:0], 4'h5});
      if (frame_start) check("frame_start_with_line_start", line_start, 1'b1);
      if (err) check("err_drops_lock_and_px", {locked, px_valid}, 2'b00);
      if (!rst_n) begin
        fs_count = 0;
        first_seen = 0;
      end
      if (px_valid) begin
        px_total++;
        if (!first_seen) begin
          first_seen = 1;
          first_x = px_x;
          first_y = px_y;
        end
      end
      if (frame_start) fs_count++;
      if (err) begin
        err_total++;
        err_gap = cyc - last_ls_cyc;
      end
      if (line_start) last_ls_cyc = cyc;
      if (locked && !lk_prev) begin
        lock_rises++;
        rise_fs = frame_start;
        rise_fs_count = fs_count;
      end
      lk_prev = locked;
    end
  end

  // ---------------- raster generator
  task automatic drive_line(input int len, input int vidx);
    logic [9:0] xx, yy;
    for (int h = 0; h < len; h++) begin
      @(negedge clk);
      hs = (h < HS_WIDTH) ? 1'b0 : 1'b1;
      vs = (vidx < VS_LINES) ? 1'b0 : 1'b1;
      if (h >= H_START && h < H_START + H_ACTIVE && vidx >= V_START && vidx < V_START + V_ACTIVE) begin
        xx = 10'(h - H_START);
        yy = 10'(vidx - V_START);
        rgb = {xx[3:0], yy[3:0], 4'h5};
      end else begin
        rgb = 12'($urandom);
      end
    end
  endtask

  task automatic gen_frame(input int nlines, input int long_idx, input int long_len);
    for (int v = 0; v < nlines; v++) drive_line((v == long_idx) ? long_len : H_TOTAL, v);
  endtask

  int p0, e0, lr0;

  initial begin
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", obs, 64'(0));
    #1 rst_n = 1'b1;
    run = 1;

    // nominal raster: lock at the third vs frame, full active window per frame
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    p0 = px_total;
    gen_frame(V_TOTAL, -1, 0);
    check("px_count_frame3", px_total - p0, FRAME_PX);
    check("lock_rise_count", lock_rises, 1);
    check("lock_rise_on_frame_start", rise_fs, 1);
    check("lock_rise_third_frame", rise_fs_count, 3);
    check("first_px_x", first_x, 0);
    check("first_px_y", first_y, 0);
    p0 = px_total;
    gen_frame(V_TOTAL, -1, 0);
    check("px_count_frame4", px_total - p0, FRAME_PX);

    // one 41-clock line while locked: one err, then two silent frames before relock
    e0 = err_total;
    gen_frame(V_TOTAL, 10, H_TOTAL + 1);
    p0 = px_total;
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    check("px_count_while_relocking", px_total - p0, 0);
    check("long_line_err_pulses", err_total - e0, 1);
    check("unlocked_before_relock", locked, 1'b0);
    p0 = px_total;
    gen_frame(V_TOTAL, -1, 0);
    check("px_count_after_relock", px_total - p0, FRAME_PX);
    check("relocked_after_long_line", locked, 1'b1);

    // asynchronous reset in the middle of a locked frame
    for (int v = 0; v < 8; v++) drive_line(H_TOTAL, v);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", obs, 64'(0));
    drive_line(H_TOTAL, 8);
    #2 rst_n = 1'b1;
    for (int v = 9; v < V_TOTAL; v++) drive_line(H_TOTAL, v);
    lr0 = lock_rises;
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    for (int v = 0; v < 3; v++) drive_line(H_TOTAL, v);
    check("relock_after_reset", lock_rises - lr0, 1);
    check("locked_after_reset", locked, 1'b1);

    // syncs stop while locked: err exactly two line periods after the last line start
    for (int v = 3; v < 6; v++) drive_line(H_TOTAL, v);
    e0 = err_total;
    repeat (150) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
      rgb = 12'($urandom);
    end
    check("sync_loss_err_pulses", err_total - e0, 1);
    check("sync_loss_err_delay", err_gap, 2 * H_TOTAL);
    check("sync_loss_unlocked", locked, 1'b0);

    // a 19-line frame during acquisition restarts the search without err
    e0 = err_total;
    lr0 = lock_rises;
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL - 1, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0);
    check("short_frame_no_lock", lock_rises - lr0, 0);
    check("short_frame_no_err", err_total - e0, 0);
    for (int v = 0; v < 3; v++) drive_line(H_TOTAL, v);
    check("lock_after_short_frame", lock_rises - lr0, 1);
    check("locked_final", locked, 1'b1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
